// File: rtl/isp8_ext_bus_arb.sv
// External port bus arbiter: stretches single-cycle core strobes and DMA requests into
// held, ack-terminated bus cycles, with a 1-deep core pending buffer and a hang timeout.
module isp8_ext_bus_arb #(
  parameter int PORT_AW     = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PORT_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_dout,
  input  logic               cpu_mem_wr,
  input  logic               cpu_mem_rd,
  input  logic               cpu_io_wr,
  input  logic               cpu_io_rd,
  output logic               cpu_stall,
  output logic [7:0]         cpu_din,
  output logic               cpu_din_vld,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic               dma_io,
  input  logic [PORT_AW-1:0] dma_addr,
  input  logic [7:0]         dma_dout,
  output logic               dma_gnt,
  output logic               dma_done,
  output logic [7:0]         dma_din,
  output logic [PORT_AW-1:0] bus_addr,
  output logic [7:0]         bus_dout,
  output logic               bus_mem_wr,
  output logic               bus_mem_rd,
  output logic               bus_io_wr,
  output logic               bus_io_rd,
  input  logic [7:0]         bus_din,
  input  logic               bus_ack,
  output logic               bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC, DONE} state_t;

  state_t             state;
  logic               pend_vld;
  logic [3:0]         pend_kind;
  logic [PORT_AW-1:0] pend_addr;
  logic [7:0]         pend_dout;
  logic [3:0]         bus_kind;
  logic [CW-1:0]      tmo_cnt;

  // Access kind vectors are one-hot {mem_wr, mem_rd, io_wr, io_rd}.
  logic [3:0]         cpu_kind;
  logic               cpu_any;
  logic [3:0]         dma_kind;
  logic [3:0]         sel_kind;
  logic [PORT_AW-1:0] sel_addr;
  logic [7:0]         sel_dout;
  logic               acc_end;
  logic               acc_rd;
  logic [7:0]         rd_val;

  assign cpu_kind = {cpu_mem_wr, cpu_mem_rd, cpu_io_wr, cpu_io_rd};
  assign cpu_any  = |cpu_kind;
  assign dma_kind = {~dma_io & dma_we, ~dma_io & ~dma_we, dma_io & dma_we, dma_io & ~dma_we};

  // A buffered access always predates a live strobe, so it is served first.
  assign sel_kind = pend_vld ? pend_kind : cpu_kind;
  assign sel_addr = pend_vld ? pend_addr : cpu_addr;
  assign sel_dout = pend_vld ? pend_dout : cpu_dout;

  assign acc_end = bus_ack || (tmo_cnt == TMO_LAST);
  assign acc_rd  = bus_kind[2] | bus_kind[0];
  assign rd_val  = bus_ack ? bus_din : 8'hFF;

  assign {bus_mem_wr, bus_mem_rd, bus_io_wr, bus_io_rd} = bus_kind;
  assign cpu_stall = cpu_any | pend_vld | (state == CPU_ACC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend_vld    <= 1'b0;
      pend_kind   <= '0;
      pend_addr   <= '0;
      pend_dout   <= '0;
      bus_kind    <= '0;
      bus_addr    <= '0;
      bus_dout    <= '0;
      tmo_cnt     <= '0;
      cpu_din     <= '0;
      cpu_din_vld <= 1'b0;
      dma_din     <= '0;
      dma_gnt     <= 1'b0;
      dma_done    <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      cpu_din_vld <= 1'b0;
      dma_done    <= 1'b0;
      bus_err     <= 1'b0;

      if (cpu_any && state != IDLE) begin
        pend_vld  <= 1'b1;
        pend_kind <= cpu_kind;
        pend_addr <= cpu_addr;
        pend_dout <= cpu_dout;
      end

      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (pend_vld || cpu_any) begin
            state    <= CPU_ACC;
            pend_vld <= 1'b0;
            bus_kind <= sel_kind;
            bus_addr <= sel_addr;
            bus_dout <= sel_dout;
          end else if (dma_req) begin
            state    <= DMA_ACC;
            dma_gnt  <= 1'b1;
            bus_kind <= dma_kind;
            bus_addr <= dma_addr;
            bus_dout <= dma_dout;
          end
        end
        CPU_ACC, DMA_ACC: begin
          if (acc_end) begin
            // A timed-out access completes like a normal one so the master never hangs.
            state    <= DONE;
            bus_kind <= '0;
            tmo_cnt  <= '0;
            bus_err  <= ~bus_ack;
            if (state == CPU_ACC) begin
              cpu_din_vld <= 1'b1;
              if (acc_rd) cpu_din <= rd_val;
            end else begin
              dma_done <= 1'b1;
              dma_gnt  <= 1'b0;
              if (acc_rd) dma_din <= rd_val;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The core is stalled whenever it cannot be accepted, so this never fires in a legal system.
  always @(posedge clk) begin
    if (rst_n) assert (!(cpu_any && (pend_vld || state == CPU_ACC)));
  end

endmodule

// File: tb/tb_isp8_ext_bus_arb.sv
// Scoreboard bench for isp8_ext_bus_arb: stimulus pushes expected bus cycles and
// completions into queues, monitors pop and compare as the DUT presents them.
module tb_isp8_ext_bus_arb;

  localparam logic [3:0] K_MEM_WR = 4'b1000;
  localparam logic [3:0] K_MEM_RD = 4'b0100;
  localparam logic [3:0] K_IO_WR  = 4'b0010;
  localparam logic [3:0] K_IO_RD  = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_dout = '0;
  logic       cpu_mem_wr = 0, cpu_mem_rd = 0, cpu_io_wr = 0, cpu_io_rd = 0;
  logic       cpu_stall, cpu_din_vld;
  logic [7:0] cpu_din;
  logic       dma_req = 0, dma_we = 0, dma_io = 0;
  logic [7:0] dma_addr = '0, dma_dout = '0;
  logic       dma_gnt, dma_done;
  logic [7:0] dma_din;
  logic [7:0] bus_addr, bus_dout;
  logic       bus_mem_wr, bus_mem_rd, bus_io_wr, bus_io_rd;
  logic [7:0] bus_din = '0;
  logic       bus_ack = 1'b0;
  logic       bus_err;

  isp8_ext_bus_arb #(.PORT_AW(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_mem_wr(cpu_mem_wr), .cpu_mem_rd(cpu_mem_rd), .cpu_io_wr(cpu_io_wr), .cpu_io_rd(cpu_io_rd),
    .cpu_stall(cpu_stall), .cpu_din(cpu_din), .cpu_din_vld(cpu_din_vld),
    .dma_req(dma_req), .dma_we(dma_we), .dma_io(dma_io), .dma_addr(dma_addr), .dma_dout(dma_dout),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_din(dma_din),
    .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_mem_wr(bus_mem_wr), .bus_mem_rd(bus_mem_rd), .bus_io_wr(bus_io_wr), .bus_io_rd(bus_io_rd),
    .bus_din(bus_din), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [3:0] kind; logic [7:0] addr; logic [7:0] dout; int len; } bus_exp_t;
  typedef struct { logic rd; logic [7:0] din; logic err; int lat; } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t cpu_q[$];
  rsp_exp_t dma_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, strobe_cyc = 0, ack_delay = 1, dma_left = 0;
  int cpu_events = 0, dma_events = 0, strb_cyc = 0, mon_len = 0;
  logic [7:0] cpu_din_model = '0, dma_din_model = '0;
  logic [3:0] mon_kind;
  logic [7:0] mon_addr, mon_dout;
  logic [3:0] bus_kind;

  assign bus_kind = {bus_mem_wr, bus_mem_rd, bus_io_wr, bus_io_rd};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void exp_bus(input logic [3:0] k, input logic [7:0] a, input logic [7:0] d, input int len);
    bus_exp_t e;
    e.kind = k; e.addr = a; e.dout = d; e.len = len;
    bus_q.push_back(e);
  endfunction

  function automatic void exp_cpu(input logic rd, input logic [7:0] din, input logic err, input int lat);
    rsp_exp_t e;
    e.rd = rd; e.din = din; e.err = err; e.lat = lat;
    cpu_q.push_back(e);
  endfunction

  function automatic void exp_dma(input logic rd, input logic [7:0] din, input logic err);
    rsp_exp_t e;
    e.rd = rd; e.din = din; e.err = err; e.lat = 0;
    dma_q.push_back(e);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave model: read data is address ^ 8'h5A; ack in the ack_delay-th strobe cycle, never if 0.
  initial forever begin
    @(negedge clk);
    strb_cyc = (bus_kind != 0) ? strb_cyc + 1 : 0;
    bus_ack  = (bus_kind != 0) && (ack_delay != 0) && (strb_cyc == ack_delay);
    bus_din  = bus_addr ^ 8'h5A;
  end

  // DMA master holds its request for dma_left accesses.
  initial forever begin
    @(negedge clk);
    if (dma_done && dma_left > 0) begin
      dma_left--;
      if (dma_left == 0) dma_req = 1'b0;
    end
  end

  initial forever begin
    bus_exp_t e;
    @(negedge clk);
    if (bus_kind != 0) begin
      if (mon_len == 0) begin
        mon_kind = bus_kind; mon_addr = bus_addr; mon_dout = bus_dout;
      end
      mon_len++;
    end else if (mon_len > 0) begin
      check_output("bus_cycle_expected", 32'(bus_q.size() != 0), 1);
      if (bus_q.size() != 0) begin
        e = bus_q.pop_front();
        check_output("bus_kind", mon_kind, e.kind);
        check_output("bus_addr", mon_addr, e.addr);
        check_output("bus_dout", mon_dout, e.dout);
        if (e.len != 0) check_output("bus_strobe_len", mon_len, e.len);
      end
      mon_len = 0;
    end
  end

  initial forever begin
    rsp_exp_t r;
    @(negedge clk);
    if (cpu_din_vld) begin
      cpu_events++;
      check_output("cpu_vld_expected", 32'(cpu_q.size() != 0), 1);
      if (cpu_q.size() != 0) begin
        r = cpu_q.pop_front();
        if (r.rd) cpu_din_model = r.din;
        check_output("cpu_din", cpu_din, cpu_din_model);
        check_output("cpu_err", bus_err, r.err);
        check_output("cpu_stall_drop", cpu_stall, 0);
        if (r.lat != 0) check_output("cpu_latency", 32'(cyc - strobe_cyc), r.lat);
      end
    end
    if (dma_done) begin
      dma_events++;
      check_output("dma_done_expected", 32'(dma_q.size() != 0), 1);
      if (dma_q.size() != 0) begin
        r = dma_q.pop_front();
        if (r.rd) dma_din_model = r.din;
        check_output("dma_din", dma_din, dma_din_model);
        check_output("dma_err", bus_err, r.err);
        check_output("dma_gnt_drop", dma_gnt, 0);
      end
    end
    if (bus_err) check_output("err_with_completion", cpu_din_vld | dma_done, 1);
  end

  task automatic apply_stimulus(input logic [3:0] k, input logic [7:0] a, input logic [7:0] d, input bit with_dma);
    @(posedge clk); #1;
    {cpu_mem_wr, cpu_mem_rd, cpu_io_wr, cpu_io_rd} = k;
    cpu_addr = a; cpu_dout = d; strobe_cyc = cyc;
    if (with_dma) dma_req = 1'b1;
    #1 check_output("stall_on_strobe", cpu_stall, 1);
    @(posedge clk); #1;
    {cpu_mem_wr, cpu_mem_rd, cpu_io_wr, cpu_io_rd} = 4'b0000;
    #1 check_output("stall_held", cpu_stall, 1);
  endtask

  task automatic dma_setup(input logic we, input logic io, input logic [7:0] a, input logic [7:0] d,
                           input int count, input bit start);
    dma_we = we; dma_io = io; dma_addr = a; dma_dout = d; dma_left = count;
    if (start) begin
      @(posedge clk); #1;
      dma_req = 1'b1;
    end
  endtask

  task automatic wait_events(input int cpu_target, input int dma_target);
    int n = 0;
    while ((cpu_events < cpu_target || dma_events < dma_target) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output("cpu_event_count", cpu_events, cpu_target);
    check_output("dma_event_count", dma_events, dma_target);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_output("reset_strobes", bus_kind, 0);
    check_output("reset_gnt", dma_gnt, 0);
    check_output("reset_stall", cpu_stall, 0);
    check_output("reset_pulses", {cpu_din_vld, dma_done, bus_err}, 0);
    check_output("reset_bus_addr", bus_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Core io write, ack in the 3rd strobe cycle.
    ack_delay = 3;
    exp_bus(K_IO_WR, 8'h12, 8'hA5, 3);
    exp_cpu(1'b0, 8'h00, 1'b0, 4);
    apply_stimulus(K_IO_WR, 8'h12, 8'hA5, 1'b0);
    wait_events(1, 0);

    // Core mem read, ack in the 1st cycle: 8'h66 ^ 8'h5A = 8'h3C.
    ack_delay = 1;
    exp_bus(K_MEM_RD, 8'h66, 8'h00, 1);
    exp_cpu(1'b1, 8'h3C, 1'b0, 2);
    apply_stimulus(K_MEM_RD, 8'h66, 8'h00, 1'b0);
    wait_events(2, 0);

    // Simultaneous DMA mem read and core io read: core first.
    ack_delay = 2;
    dma_setup(1'b0, 1'b0, 8'h20, 8'hC3, 1, 1'b0);
    exp_bus(K_IO_RD, 8'h30, 8'h00, 2);
    exp_bus(K_MEM_RD, 8'h20, 8'hC3, 2);
    exp_cpu(1'b1, 8'h6A, 1'b0, 3);
    exp_dma(1'b1, 8'h7A, 1'b0);
    apply_stimulus(K_IO_RD, 8'h30, 8'h00, 1'b1);
    check_output("gnt_while_cpu", dma_gnt, 0);
    wait_events(3, 1);

    // Core strobe while DMA in flight is buffered and beats the DMA's next request.
    ack_delay = 4;
    exp_bus(K_IO_WR, 8'h50, 8'h77, 4);
    exp_bus(K_MEM_WR, 8'h51, 8'h88, 4);
    exp_bus(K_IO_WR, 8'h50, 8'h77, 4);
    exp_dma(1'b0, 8'h00, 1'b0);
    exp_cpu(1'b0, 8'h00, 1'b0, 0);
    exp_dma(1'b0, 8'h00, 1'b0);
    dma_setup(1'b1, 1'b1, 8'h50, 8'h77, 2, 1'b1);
    apply_stimulus(K_MEM_WR, 8'h51, 8'h88, 1'b0);
    check_output("gnt_during_dma", dma_gnt, 1);
    wait_events(4, 3);

    // Core io read with no ack: timeout after 16 strobe cycles.
    ack_delay = 0;
    exp_bus(K_IO_RD, 8'h70, 8'h00, 16);
    exp_cpu(1'b1, 8'hFF, 1'b1, 17);
    apply_stimulus(K_IO_RD, 8'h70, 8'h00, 1'b0);
    wait_events(5, 3);

    // Reset during a hung DMA access.
    exp_bus(K_MEM_RD, 8'h80, 8'h00, 0);
    dma_setup(1'b0, 1'b0, 8'h80, 8'h00, 1, 1'b1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0; dma_req = 1'b0; dma_left = 0;
    #1;
    check_output("rst_strobes_drop", bus_kind, 0);
    check_output("rst_gnt_drop", dma_gnt, 0);
    check_output("rst_stall_drop", cpu_stall, 0);
    cpu_din_model = '0;
    dma_din_model = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("post_rst_idle_bus", bus_kind, 0);
    check_output("post_rst_idle_gnt", dma_gnt, 0);
    check_output("post_rst_cpu_din", cpu_din, cpu_din_model);
    check_output("post_rst_dma_din", dma_din, dma_din_model);

    ack_delay = 1;
    exp_bus(K_IO_WR, 8'h99, 8'h11, 1);
    exp_cpu(1'b0, 8'h00, 1'b0, 2);
    apply_stimulus(K_IO_WR, 8'h99, 8'h11, 1'b0);
    wait_events(6, 3);

    check_output("bus_q_drained", bus_q.size(), 0);
    check_output("cpu_q_drained", cpu_q.size(), 0);
    check_output("dma_q_drained", dma_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
